// File: rtl/inst_enc_pkg.sv
// Shared types for the RV32I encoder/loader: operation index, instruction formats,
// major opcodes, and the per-operation opcode/funct3/funct7 lookup.
package inst_enc_pkg;

    typedef enum logic [5:0] {
        OP_LUI = 6'd0, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ECALL, OP_EBREAK, OP_MRET, OP_WFI,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
    } enc_op_e;

    typedef enum logic [3:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_SYS, FMT_CSR, FMT_BAD
    } fmt_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FULL} state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_0       = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] f12;
        fmt_e        fmt;
    } op_info_t;

    // Indices past the last defined operation fall through to FMT_BAD.
    function automatic op_info_t op_info(input logic [5:0] op);
        op_info_t r;
        r = '{OPC_OP, 3'd0, F7_0, 12'd0, FMT_BAD};
        case (op)
            OP_LUI:    r = '{OPC_LUI,    3'd0, F7_0,   12'd0, FMT_U};
            OP_AUIPC:  r = '{OPC_AUIPC,  3'd0, F7_0,   12'd0, FMT_U};
            OP_JAL:    r = '{OPC_JAL,    3'd0, F7_0,   12'd0, FMT_J};
            OP_JALR:   r = '{OPC_JALR,   3'd0, F7_0,   12'd0, FMT_I};
            OP_BEQ:    r = '{OPC_BRANCH, 3'd0, F7_0,   12'd0, FMT_B};
            OP_BNE:    r = '{OPC_BRANCH, 3'd1, F7_0,   12'd0, FMT_B};
            OP_BLT:    r = '{OPC_BRANCH, 3'd4, F7_0,   12'd0, FMT_B};
            OP_BGE:    r = '{OPC_BRANCH, 3'd5, F7_0,   12'd0, FMT_B};
            OP_BLTU:   r = '{OPC_BRANCH, 3'd6, F7_0,   12'd0, FMT_B};
            OP_BGEU:   r = '{OPC_BRANCH, 3'd7, F7_0,   12'd0, FMT_B};
            OP_LB:     r = '{OPC_LOAD,   3'd0, F7_0,   12'd0, FMT_I};
            OP_LH:     r = '{OPC_LOAD,   3'd1, F7_0,   12'd0, FMT_I};
            OP_LW:     r = '{OPC_LOAD,   3'd2, F7_0,   12'd0, FMT_I};
            OP_LBU:    r = '{OPC_LOAD,   3'd4, F7_0,   12'd0, FMT_I};
            OP_LHU:    r = '{OPC_LOAD,   3'd5, F7_0,   12'd0, FMT_I};
            OP_SB:     r = '{OPC_STORE,  3'd0, F7_0,   12'd0, FMT_S};
            OP_SH:     r = '{OPC_STORE,  3'd1, F7_0,   12'd0, FMT_S};
            OP_SW:     r = '{OPC_STORE,  3'd2, F7_0,   12'd0, FMT_S};
            OP_ADDI:   r = '{OPC_OPIMM,  3'd0, F7_0,   12'd0, FMT_I};
            OP_SLTI:   r = '{OPC_OPIMM,  3'd2, F7_0,   12'd0, FMT_I};
            OP_SLTIU:  r = '{OPC_OPIMM,  3'd3, F7_0,   12'd0, FMT_I};
            OP_XORI:   r = '{OPC_OPIMM,  3'd4, F7_0,   12'd0, FMT_I};
            OP_ORI:    r = '{OPC_OPIMM,  3'd6, F7_0,   12'd0, FMT_I};
            OP_ANDI:   r = '{OPC_OPIMM,  3'd7, F7_0,   12'd0, FMT_I};
            OP_SLLI:   r = '{OPC_OPIMM,  3'd1, F7_0,   12'd0, FMT_SH};
            OP_SRLI:   r = '{OPC_OPIMM,  3'd5, F7_0,   12'd0, FMT_SH};
            OP_SRAI:   r = '{OPC_OPIMM,  3'd5, F7_ALT, 12'd0, FMT_SH};
            OP_ADD:    r = '{OPC_OP,     3'd0, F7_0,   12'd0, FMT_R};
            OP_SUB:    r = '{OPC_OP,     3'd0, F7_ALT, 12'd0, FMT_R};
            OP_SLL:    r = '{OPC_OP,     3'd1, F7_0,   12'd0, FMT_R};
            OP_SLT:    r = '{OPC_OP,     3'd2, F7_0,   12'd0, FMT_R};
            OP_SLTU:   r = '{OPC_OP,     3'd3, F7_0,   12'd0, FMT_R};
            OP_XOR:    r = '{OPC_OP,     3'd4, F7_0,   12'd0, FMT_R};
            OP_SRL:    r = '{OPC_OP,     3'd5, F7_0,   12'd0, FMT_R};
            OP_SRA:    r = '{OPC_OP,     3'd5, F7_ALT, 12'd0, FMT_R};
            OP_OR:     r = '{OPC_OP,     3'd6, F7_0,   12'd0, FMT_R};
            OP_AND:    r = '{OPC_OP,     3'd7, F7_0,   12'd0, FMT_R};
            OP_ECALL:  r = '{OPC_SYSTEM, 3'd0, F7_0,   12'h000, FMT_SYS};
            OP_EBREAK: r = '{OPC_SYSTEM, 3'd0, F7_0,   12'h001, FMT_SYS};
            OP_MRET:   r = '{OPC_SYSTEM, 3'd0, F7_0,   12'h302, FMT_SYS};
            OP_WFI:    r = '{OPC_SYSTEM, 3'd0, F7_0,   12'h105, FMT_SYS};
            OP_CSRRW:  r = '{OPC_SYSTEM, 3'd1, F7_0,   12'd0, FMT_CSR};
            OP_CSRRS:  r = '{OPC_SYSTEM, 3'd2, F7_0,   12'd0, FMT_CSR};
            OP_CSRRC:  r = '{OPC_SYSTEM, 3'd3, F7_0,   12'd0, FMT_CSR};
            OP_CSRRWI: r = '{OPC_SYSTEM, 3'd5, F7_0,   12'd0, FMT_CSR};
            OP_CSRRSI: r = '{OPC_SYSTEM, 3'd6, F7_0,   12'd0, FMT_CSR};
            OP_CSRRCI: r = '{OPC_SYSTEM, 3'd7, F7_0,   12'd0, FMT_CSR};
            default:   r = '{OPC_OP,     3'd0, F7_0,   12'd0, FMT_BAD};
        endcase
        return r;
    endfunction

    // True when v[31:lsb] is a pure sign extension (all zeros or all ones).
    function automatic logic imm_fits(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = 32'($signed(v) >>> lsb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Symbolic-instruction input stream plus the imem write port of the encoder/loader.
// master = program source / imem side, slave = the loader.
interface inst_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [5:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_last, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_last, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_encoder_loader_field_packer.sv
// Packs one symbolic RV32I instruction into its machine word and flags illegal fields.
// Purely combinational; no state, no backpressure.
module inst_field_packer
    import inst_enc_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);
    op_info_t w_info;

    assign w_info = op_info(i_op);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (w_info.fmt)
            FMT_R:   o_word = {w_info.f7, i_rs2, i_rs1, w_info.f3, i_rd, w_info.opc};
            FMT_I: begin
                o_word    = {i_imm[11:0], i_rs1, w_info.f3, i_rd, w_info.opc};
                o_illegal = !imm_fits(i_imm, 11);
            end
            FMT_S: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, w_info.f3, i_imm[4:0], w_info.opc};
                o_illegal = !imm_fits(i_imm, 11);
            end
            FMT_B: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_info.f3,
                             i_imm[4:1], i_imm[11], w_info.opc};
                o_illegal = !imm_fits(i_imm, 12) || i_imm[0];
            end
            FMT_U: begin
                o_word    = {i_imm[31:12], i_rd, w_info.opc};
                o_illegal = |i_imm[11:0];
            end
            FMT_J: begin
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_info.opc};
                o_illegal = !imm_fits(i_imm, 20) || i_imm[0];
            end
            FMT_SH: begin
                o_word    = {w_info.f7, i_imm[4:0], i_rs1, w_info.f3, i_rd, w_info.opc};
                o_illegal = |i_imm[31:5];
            end
            FMT_SYS: o_word = {w_info.f12, 13'd0, w_info.opc};
            // rs1 carries either a register or the 5-bit zimm; both land in the same field.
            FMT_CSR: o_word = {i_imm[11:0], i_rs1, w_info.f3, i_rd, w_info.opc};
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/inst_encoder_loader.sv
// Session FSM and imem writer: encodes accepted beats, writes legal words one cycle later.
// in_ready only while loading; a full session holds off the source until start or reset.
module inst_encoder_loader
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    inst_encoder_loader_if.slave bus,
    output logic                 err_illegal,
    output logic [ERR_W-1:0]     err_count,
    output logic [ADDR_W:0]      words_written,
    output logic                 busy
);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                w_accept;
    logic                w_illegal;
    logic                w_reaches_depth;
    logic [31:0]         w_word;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic                r_err_p;
    logic [ERR_W-1:0]    r_err_cnt;
    logic [ADDR_W:0]     r_words;

    inst_field_packer u_packer (
        .i_op      (bus.in_op),
        .i_rd      (bus.in_rd),
        .i_rs1     (bus.in_rs1),
        .i_rs2     (bus.in_rs2),
        .i_imm     (bus.in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_accept        = bus.in_valid && (r_state == ST_LOAD);
    assign w_reaches_depth = !w_illegal && ((r_words + (ADDR_W+1)'(1)) == DEPTH_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                // in_last wins over the depth limit: the session closes either way.
                if (w_accept && bus.in_last)          w_state_nxt = ST_IDLE;
                else if (w_accept && w_reaches_depth) w_state_nxt = ST_FULL;
            end
            ST_FULL: if (start) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_imem_addr <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_err_p     <= 1'b0;
            r_err_cnt   <= '0;
            r_words     <= '0;
        end else begin
            r_we    <= 1'b0;
            r_err_p <= 1'b0;
            if (r_state == ST_IDLE && start) begin
                r_addr    <= base_addr;
                r_err_cnt <= '0;
                r_words   <= '0;
            end else if (w_accept) begin
                if (w_illegal) begin
                    r_err_p <= 1'b1;
                    if (r_err_cnt != {ERR_W{1'b1}}) r_err_cnt <= r_err_cnt + ERR_W'(1);
                end else begin
                    r_we        <= 1'b1;
                    r_imem_addr <= r_addr;
                    r_wdata     <= w_word;
                    r_addr      <= r_addr + ADDR_W'(1);
                    r_words     <= r_words + (ADDR_W+1)'(1);
                end
            end
        end
    end

    assign bus.in_ready   = (r_state == ST_LOAD);
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_wdata;
    assign err_illegal    = r_err_p;
    assign err_count      = r_err_cnt;
    assign words_written  = r_words;
    assign busy           = (r_state != ST_IDLE);
endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed programs, a reference assembler/session model
// compared every cycle, plus literal machine words and addresses.
module tb_inst_encoder_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int ERR_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              err_illegal;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W:0]   words_written;
    logic              busy;

    inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .bus           (bus),
        .err_illegal   (err_illegal),
        .err_count     (err_count),
        .words_written (words_written),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference assembler: ISA field layouts and legal immediate ranges.
    function automatic int ref_f3(input int op);
        case (op)
            5, 11, 16, 24, 29, 41:         return 1;
            12, 17, 19, 30, 42:            return 2;
            20, 31, 43:                    return 3;
            6, 13, 21, 32:                 return 4;
            7, 14, 25, 26, 33, 34, 44:     return 5;
            8, 22, 35, 45:                 return 6;
            9, 23, 36, 46:                 return 7;
            default:                       return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input logic [31:0] imm, output bit bad);
        int s;
        int f3;
        logic [31:0] w;
        s   = $signed(imm);
        f3  = ref_f3(op);
        bad = 0;
        w   = 0;
        if (op == 0 || op == 1) begin
            bad = (imm % 4096) != 0;
            w = (imm & 32'hFFFFF000) | (rd << 7) | (op == 0 ? 32'h37 : 32'h17);
        end else if (op == 2) begin
            bad = s < -(1 << 20) || s >= (1 << 20) || (s % 2 != 0);
            w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
              | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
        end else if (op >= 4 && op <= 9) begin
            bad = s < -4096 || s > 4095 || (s % 2 != 0);
            w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
              | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
        end else if (op >= 15 && op <= 17) begin
            bad = s < -2048 || s > 2047;
            w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | ((imm & 32'h1F) << 7) | 32'h23;
        end else if (op == 3 || (op >= 10 && op <= 14) || (op >= 18 && op <= 23)) begin
            bad = s < -2048 || s > 2047;
            w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7)
              | (op == 3 ? 32'h67 : (op <= 14 ? 32'h03 : 32'h13));
        end else if (op >= 24 && op <= 26) begin
            bad = imm > 31;
            w = ((op == 26 ? 32'h20 : 0) << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12)
              | (rd << 7) | 32'h13;
        end else if (op >= 27 && op <= 36) begin
            w = ((op == 28 || op == 34 ? 32'h20 : 0) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | (rd << 7) | 32'h33;
        end else if (op == 37) w = 32'h00000073;
        else if (op == 38)     w = 32'h00100073;
        else if (op == 39)     w = 32'h30200073;
        else if (op == 40)     w = 32'h10500073;
        else if (op >= 41 && op <= 46) begin
            w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h73;
        end else bad = 1;
        return w;
    endfunction

    // Session model: 0 idle, 1 loading, 2 full.
    int          m_state, m_addr, m_err, m_ww, m_waddr;
    logic        m_we, m_errp;
    logic [31:0] m_wdata;

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] w;
        bit bad;
        if (rst) begin
            m_state <= 0; m_addr <= 0; m_err <= 0; m_ww <= 0;
            m_we <= 0; m_errp <= 0; m_waddr <= 0; m_wdata <= 0;
        end else begin
            m_we   <= 0;
            m_errp <= 0;
            if (m_state == 0) begin
                if (start) begin
                    m_state <= 1; m_addr <= int'(base_addr); m_err <= 0; m_ww <= 0;
                end
            end else if (m_state == 2) begin
                if (start) m_state <= 0;
            end else if (bus.in_valid) begin
                w = ref_enc(int'(bus.in_op), int'(bus.in_rd), int'(bus.in_rs1),
                            int'(bus.in_rs2), bus.in_imm, bad);
                if (bad) begin
                    m_errp <= 1;
                    m_err  <= (m_err < (1 << ERR_W) - 1) ? m_err + 1 : m_err;
                end else begin
                    m_we    <= 1;
                    m_waddr <= m_addr;
                    m_wdata <= w;
                    m_addr  <= (m_addr + 1) % (1 << ADDR_W);
                    m_ww    <= m_ww + 1;
                end
                if (bus.in_last)                     m_state <= 0;
                else if (!bad && m_ww + 1 == DEPTH)  m_state <= 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_imem_we",       bus.imem_we,    m_we);
            chk("cyc_imem_addr",     bus.imem_addr,  m_waddr);
            chk("cyc_imem_wdata",    bus.imem_wdata, m_wdata);
            chk("cyc_err_illegal",   err_illegal,    m_errp);
            chk("cyc_err_count",     err_count,      m_err);
            chk("cyc_words_written", words_written,  m_ww);
            chk("cyc_busy",          busy,           m_state != 0);
            chk("cyc_in_ready",      bus.in_ready,   m_state == 1);
        end
    end

    task automatic drive(input int op, input int rd, input int rs1, input int rs2,
                         input logic [31:0] imm, input bit last);
        bus.in_valid = 1'b1;
        bus.in_op    = 6'(op);
        bus.in_rd    = 5'(rd);
        bus.in_rs1   = 5'(rs1);
        bus.in_rs2   = 5'(rs2);
        bus.in_imm   = imm;
        bus.in_last  = last;
    endtask

    // Called at a negedge; returns at the negedge after the beat was taken.
    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input bit last);
        drive(op, rd, rs1, rs2, imm, last);
        for (int k = 0; k < 20 && !bus.in_ready; k++) @(negedge clk);
        chk("send_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic open_session(input logic [ADDR_W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_op = '0;
        bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1;
        chk("rst_imem_we", bus.imem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_words", words_written, 0);

        open_session(10'h010);
        chk("a_busy", busy, 1);
        send(18, 1, 0, 0, 32'd5, 0);
        chk("addi_we", bus.imem_we, 1);
        chk("addi_addr", bus.imem_addr, 32'h010);
        chk("addi_word", bus.imem_wdata, 32'h00500093);
        send(4, 0, 1, 2, -32'sd4, 0);
        chk("beq_addr", bus.imem_addr, 32'h011);
        chk("beq_word", bus.imem_wdata, 32'hFE208EE3);
        send(2, 1, 0, 0, 32'd3, 0);
        chk("jal_odd_err", err_illegal, 1);
        chk("jal_odd_cnt", err_count, 1);
        chk("jal_odd_we", bus.imem_we, 0);
        send(0, 2, 0, 0, 32'h12345001, 1);
        chk("lui_bad_err", err_illegal, 1);
        chk("lui_bad_cnt", err_count, 2);
        chk("lui_bad_closes", busy, 0);
        chk("a_words", words_written, 2);

        open_session(10'h3FE);
        send(26, 5, 5, 0, 32'd3, 0);
        chk("srai_addr", bus.imem_addr, 32'h3FE);
        chk("srai_word", bus.imem_wdata, 32'h4032D293);
        send(0, 2, 0, 0, 32'h12345000, 0);
        chk("lui_addr", bus.imem_addr, 32'h3FF);
        chk("lui_word", bus.imem_wdata, 32'h12345137);
        send(45, 3, 7, 0, 32'h300, 0);
        chk("csrrsi_wrap_addr", bus.imem_addr, 32'h000);
        chk("csrrsi_word", bus.imem_wdata, 32'h3003E1F3);
        send(37, 0, 0, 0, 32'd0, 0);
        chk("ecall_addr", bus.imem_addr, 32'h001);
        chk("ecall_word", bus.imem_wdata, 32'h00000073);
        chk("full_words", words_written, 4);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_busy", busy, 1);
        drive(38, 0, 0, 0, 32'd0, 0);
        repeat (3) @(negedge clk);
        chk("full_no_write", bus.imem_we, 0);
        chk("full_words_hold", words_written, 4);
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("full_start_idle", busy, 0);

        open_session(10'h100);
        drive(39, 0, 0, 0, 32'd0, 0);
        @(negedge clk);
        chk("mret_word", bus.imem_wdata, 32'h30200073);
        chk("mret_addr", bus.imem_addr, 32'h100);
        drive(40, 0, 0, 0, 32'd0, 0);
        @(negedge clk);
        chk("wfi_word", bus.imem_wdata, 32'h10500073);
        drive(27, 1, 2, 3, 32'd0, 1);
        @(negedge clk);
        chk("add_word", bus.imem_wdata, 32'h003100B3);
        chk("burst_busy_drop", busy, 0);
        drive(38, 0, 0, 0, 32'd0, 0);
        @(negedge clk);
        chk("after_last_no_we", bus.imem_we, 0);
        chk("after_last_words", words_written, 3);
        @(negedge clk);
        chk("after_last_no_we2", bus.imem_we, 0);
        bus.in_valid = 1'b0;

        open_session(10'h200);
        send(50, 1, 1, 1, 32'd0, 0);
        chk("op50_err", err_illegal, 1);
        chk("op50_cnt", err_count, 1);
        send(38, 0, 0, 0, 32'd0, 0);
        chk("ebreak_addr", bus.imem_addr, 32'h200);
        chk("ebreak_word", bus.imem_wdata, 32'h00100073);
        drive(28, 3, 1, 2, 32'd0, 0);
        @(posedge clk);
        #1;
        chk("sub_we", bus.imem_we, 1);
        chk("sub_word", bus.imem_wdata, 32'h402081B3);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", bus.imem_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_words", words_written, 0);
        chk("post_rst_err", err_count, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
